// File: rtl/io_arbiter.sv
// io_arbiter: two-requester round-robin arbiter in front of a single IO space.
// Each granted transaction runs IDLE -> ISSUE -> CAPT -> ACK -> IDLE, so it
// occupies the arbiter for exactly four cycles. Read data is returned 3 cycles
// after the IDLE cycle that sampled the request.
//
// Ports
//   CLK, RESET_N               clock; asynchronous active-low reset
//   R0_REQ/WE/RE/ADDR/WD       requester 0 (CPU) request and payload
//   R0_ACK, R0_RD              requester 0 completion pulse and read data
//   R1_*                       same as R0_* for requester 1 (debug/DMA)
//   IO_REQ/WE/RE/ADDR/WD       downstream request (IO_REQ is high in ISSUE only)
//   IO_RD                      downstream read data, valid the cycle after IO_REQ
//   BUSY                       high while a transaction is in flight
//   LAST_GNT                   index of the most recently granted requester
module io_arbiter #(
  parameter int unsigned RAM_DEPTH = 14
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 R0_REQ,
  input  logic                 R0_WE,
  input  logic                 R0_RE,
  input  logic [RAM_DEPTH-1:0] R0_ADDR,
  input  logic [31:0]          R0_WD,
  output logic                 R0_ACK,
  output logic [31:0]          R0_RD,
  input  logic                 R1_REQ,
  input  logic                 R1_WE,
  input  logic                 R1_RE,
  input  logic [RAM_DEPTH-1:0] R1_ADDR,
  input  logic [31:0]          R1_WD,
  output logic                 R1_ACK,
  output logic [31:0]          R1_RD,
  output logic                 IO_REQ,
  output logic                 IO_WE,
  output logic                 IO_RE,
  output logic [RAM_DEPTH-1:0] IO_ADDR,
  output logic [31:0]          IO_WD,
  input  logic [31:0]          IO_RD,
  output logic                 BUSY,
  output logic                 LAST_GNT
);

  localparam int unsigned AW = RAM_DEPTH;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            gnt_q, gnt_d;
  logic            last_gnt_q, last_gnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wd_q, wd_d;
  logic            io_req_q, io_req_d;
  logic            io_we_q, io_we_d;
  logic            io_re_q, io_re_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic [DW-1:0]   rd0_q, rd0_d;
  logic [DW-1:0]   rd1_q, rd1_d;
  logic            busy_q, busy_d;

  // Winner selection: a lone requester wins; on a tie the one not granted last wins.
  logic            win_idx;
  logic            sel_we;
  logic            sel_re;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wd;

  assign win_idx  = (R0_REQ && R1_REQ) ? ~last_gnt_q : R1_REQ;
  assign sel_we   = win_idx ? R1_WE   : R0_WE;
  assign sel_re   = win_idx ? R1_RE   : R0_RE;
  assign sel_addr = win_idx ? R1_ADDR : R0_ADDR;
  assign sel_wd   = win_idx ? R1_WD   : R0_WD;

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    io_req_d   = 1'b0;
    io_we_d    = 1'b0;
    io_re_d    = 1'b0;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    rd0_d      = rd0_q;
    rd1_d      = rd1_q;
    busy_d     = busy_q;

    case (state_q)
      IDLE: begin
        if (R0_REQ || R1_REQ) begin
          state_d    = ISSUE;
          gnt_d      = win_idx;
          last_gnt_d = win_idx;
          busy_d     = 1'b1;
          // IO strobes are loaded now so they are high exactly during ISSUE.
          io_req_d   = 1'b1;
          io_we_d    = sel_we;
          io_re_d    = sel_re & ~sel_we;  // write takes priority over read
          addr_d     = sel_addr;
          wd_d       = sel_wd;
        end
      end
      ISSUE: begin
        state_d = CAPT;
      end
      CAPT: begin
        // IO_RD is valid in this cycle; capture it and raise the winner's ACK.
        state_d = ACK;
        if (gnt_q) begin
          rd1_d  = IO_RD;
          ack1_d = 1'b1;
        end else begin
          rd0_d  = IO_RD;
          ack0_d = 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      addr_q     <= '0;
      wd_q       <= '0;
      io_req_q   <= 1'b0;
      io_we_q    <= 1'b0;
      io_re_q    <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rd0_q      <= '0;
      rd1_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      io_req_q   <= io_req_d;
      io_we_q    <= io_we_d;
      io_re_q    <= io_re_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rd0_q      <= rd0_d;
      rd1_q      <= rd1_d;
      busy_q     <= busy_d;
    end
  end

  assign R0_ACK   = ack0_q;
  assign R0_RD    = rd0_q;
  assign R1_ACK   = ack1_q;
  assign R1_RD    = rd1_q;
  assign IO_REQ   = io_req_q;
  assign IO_WE    = io_we_q;
  assign IO_RE    = io_re_q;
  assign IO_ADDR  = addr_q;
  assign IO_WD    = wd_q;
  assign BUSY     = busy_q;
  assign LAST_GNT = last_gnt_q;

endmodule

// File: tb/tb_io_arbiter.sv
// tb_io_arbiter: directed scenarios plus randomized traffic for io_arbiter,
// checked every cycle against a transaction-level model (grant time + phase).
module tb_io_arbiter;

  localparam int unsigned AW = 14;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b1;
  logic          R0_REQ = 1'b0, R0_WE = 1'b0, R0_RE = 1'b0;
  logic [AW-1:0] R0_ADDR = '0;
  logic [31:0]   R0_WD = '0;
  logic          R0_ACK;
  logic [31:0]   R0_RD;
  logic          R1_REQ = 1'b0, R1_WE = 1'b0, R1_RE = 1'b0;
  logic [AW-1:0] R1_ADDR = '0;
  logic [31:0]   R1_WD = '0;
  logic          R1_ACK;
  logic [31:0]   R1_RD;
  logic          IO_REQ, IO_WE, IO_RE;
  logic [AW-1:0] IO_ADDR;
  logic [31:0]   IO_WD;
  logic [31:0]   IO_RD = '0;
  logic          BUSY, LAST_GNT;

  int nvec = 0;
  int nerr = 0;

  io_arbiter #(.RAM_DEPTH(AW)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .R0_REQ(R0_REQ), .R0_WE(R0_WE), .R0_RE(R0_RE), .R0_ADDR(R0_ADDR), .R0_WD(R0_WD),
    .R0_ACK(R0_ACK), .R0_RD(R0_RD),
    .R1_REQ(R1_REQ), .R1_WE(R1_WE), .R1_RE(R1_RE), .R1_ADDR(R1_ADDR), .R1_WD(R1_WD),
    .R1_ACK(R1_ACK), .R1_RD(R1_RD),
    .IO_REQ(IO_REQ), .IO_WE(IO_WE), .IO_RE(IO_RE), .IO_ADDR(IO_ADDR), .IO_WD(IO_WD),
    .IO_RD(IO_RD), .BUSY(BUSY), .LAST_GNT(LAST_GNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: a grant at edge m_tg puts the transaction in
  // phase (edge_count - m_tg): 0 = request on IO, 2 = ACK, 3 = done.
  int            m_cyc = 0;
  int            m_tg = 0;
  int            m_win = 0;
  bit            m_active = 1'b0;
  bit            m_last = 1'b1;
  bit            m_we = 1'b0, m_re = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0]   m_wd = '0;
  logic [31:0]   m_rd [2] = '{32'd0, 32'd0};

  initial forever begin
    @(posedge CLK or negedge RESET_N);
    if (!RESET_N) begin
      m_active = 1'b0;
      m_last   = 1'b1;
      m_we     = 1'b0;
      m_re     = 1'b0;
      m_addr   = '0;
      m_wd     = '0;
      m_rd[0]  = '0;
      m_rd[1]  = '0;
    end else begin
      m_cyc++;
      if (m_active) begin
        if (m_cyc - m_tg == 2) m_rd[m_win] = IO_RD;
        if (m_cyc - m_tg == 3) m_active = 1'b0;
      end else if (R0_REQ || R1_REQ) begin
        if (R0_REQ && R1_REQ) m_win = m_last ? 0 : 1;
        else                  m_win = R1_REQ ? 1 : 0;
        m_last   = (m_win == 1);
        m_active = 1'b1;
        m_tg     = m_cyc;
        m_we     = (m_win == 1) ? R1_WE   : R0_WE;
        m_re     = (m_win == 1) ? R1_RE   : R0_RE;
        m_addr   = (m_win == 1) ? R1_ADDR : R0_ADDR;
        m_wd     = (m_win == 1) ? R1_WD   : R0_WD;
      end
    end
  end

  // Compare process: all outputs against the model, every cycle.
  initial forever begin
    bit e_issue, e_ack;
    @(negedge CLK);
    e_issue = m_active && (m_cyc - m_tg == 0);
    e_ack   = m_active && (m_cyc - m_tg == 2);
    chk("busy",     32'(BUSY),     32'(m_active));
    chk("last_gnt", 32'(LAST_GNT), 32'(m_last));
    chk("io_req",   32'(IO_REQ),   32'(e_issue));
    chk("io_we",    32'(IO_WE),    32'(e_issue && m_we));
    chk("io_re",    32'(IO_RE),    32'(e_issue && m_re && !m_we));
    chk("io_addr",  32'(IO_ADDR),  32'(m_addr));
    chk("io_wd",    IO_WD,         m_wd);
    chk("r0_ack",   32'(R0_ACK),   32'(e_ack && m_win == 0));
    chk("r1_ack",   32'(R1_ACK),   32'(e_ack && m_win == 1));
    chk("r0_rd",    R0_RD,         m_rd[0]);
    chk("r1_rd",    R1_RD,         m_rd[1]);
  end

  task automatic idle_inputs();
    R0_REQ = 1'b0; R0_WE = 1'b0; R0_RE = 1'b0;
    R1_REQ = 1'b0; R1_WE = 1'b0; R1_RE = 1'b0;
  endtask

  // Leaves the bench just after a negedge, with the next posedge the first
  // one seen with RESET_N high.
  task automatic do_reset();
    idle_inputs();
    @(negedge CLK);
    #1 RESET_N = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #1 RESET_N = 1'b1;
  endtask

  // Leaves the bench at a negedge with the arbiter idle.
  task automatic settle();
    idle_inputs();
    repeat (5) @(negedge CLK);
  endtask

  initial begin
    #1 RESET_N = 1'b0;
    @(negedge CLK);
    chk("rst_busy",     32'(BUSY),     32'd0);
    chk("rst_last_gnt", 32'(LAST_GNT), 32'd1);
    chk("rst_io_req",   32'(IO_REQ),   32'd0);
    chk("rst_r0_rd",    R0_RD,         32'd0);
    chk("rst_r1_rd",    R1_RD,         32'd0);
    @(negedge CLK);
    #1 RESET_N = 1'b1;

    // R0 read at 0x010, IO returns 0xDEADBEEF.
    settle();
    do_reset();
    R0_REQ = 1'b1; R0_RE = 1'b1; R0_ADDR = AW'(14'h010);
    @(negedge CLK);
    chk("s1_io_req",  32'(IO_REQ),  32'd1);
    chk("s1_io_re",   32'(IO_RE),   32'd1);
    chk("s1_io_we",   32'(IO_WE),   32'd0);
    chk("s1_io_addr", 32'(IO_ADDR), 32'h010);
    IO_RD = 32'hDEADBEEF;
    @(negedge CLK);
    chk("s1_io_req_c2", 32'(IO_REQ), 32'd0);
    @(negedge CLK);
    chk("s1_r0_ack", 32'(R0_ACK), 32'd1);
    chk("s1_r1_ack", 32'(R1_ACK), 32'd0);
    chk("s1_r0_rd",  R0_RD,       32'hDEADBEEF);
    chk("s1_r1_rd",  R1_RD,       32'd0);
    R0_REQ = 1'b0;
    IO_RD = 32'h0;
    @(negedge CLK);
    chk("s1_busy_c4", 32'(BUSY),  32'd0);
    chk("s1_r0_hold", R0_RD,      32'hDEADBEEF);

    // Both requesters hold REQ: R0, R1, R0, R1 at 4-cycle spacing.
    settle();
    do_reset();
    R0_REQ = 1'b1; R1_REQ = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge CLK);
      chk("s2_r0_ack", 32'(R0_ACK), 32'(k == 3 || k == 11));
      chk("s2_r1_ack", 32'(R1_ACK), 32'(k == 7 || k == 15));
      if (k == 1) chk("s2_gnt_r0", 32'(LAST_GNT), 32'd0);
      if (k == 5) chk("s2_gnt_r1", 32'(LAST_GNT), 32'd1);
    end
    idle_inputs();

    // R1 write with WE=RE=1 is issued as a write; later input changes ignored.
    settle();
    R1_REQ = 1'b1; R1_WE = 1'b1; R1_RE = 1'b1;
    R1_ADDR = AW'(14'h030); R1_WD = 32'h12345678;
    @(negedge CLK);
    chk("s3_io_req",  32'(IO_REQ),  32'd1);
    chk("s3_io_we",   32'(IO_WE),   32'd1);
    chk("s3_io_re",   32'(IO_RE),   32'd0);
    chk("s3_io_addr", 32'(IO_ADDR), 32'h030);
    chk("s3_io_wd",   IO_WD,        32'h12345678);
    R1_ADDR = AW'(14'h3FF); R1_WD = 32'h0; R1_WE = 1'b0;
    @(negedge CLK);
    chk("s3_one_issue", 32'(IO_REQ),  32'd0);
    chk("s3_we_low",    32'(IO_WE),   32'd0);
    chk("s3_addr_hold", 32'(IO_ADDR), 32'h030);
    @(negedge CLK);
    chk("s3_r1_ack", 32'(R1_ACK), 32'd1);
    R1_REQ = 1'b0;

    // R0 drops REQ during CAPT; ACK still pulses, then idle.
    settle();
    R0_REQ = 1'b1; R0_RE = 1'b1; R0_ADDR = AW'(14'h123);
    @(negedge CLK);
    @(negedge CLK);
    R0_REQ = 1'b0;
    @(negedge CLK);
    chk("s4_r0_ack", 32'(R0_ACK), 32'd1);
    @(negedge CLK);
    chk("s4_idle_a", 32'(BUSY), 32'd0);
    @(negedge CLK);
    chk("s4_idle_b", 32'(BUSY), 32'd0);

    // Reset pulse during ISSUE aborts with no ACK.
    settle();
    R1_REQ = 1'b1; R1_RE = 1'b1;
    @(negedge CLK);
    chk("s5_issue", 32'(IO_REQ), 32'd1);
    #1 RESET_N = 1'b0;
    #1;
    chk("s5_io_req",   32'(IO_REQ),   32'd0);
    chk("s5_busy",     32'(BUSY),     32'd0);
    chk("s5_last_gnt", 32'(LAST_GNT), 32'd1);
    idle_inputs();
    for (int k = 2; k <= 4; k++) begin
      @(negedge CLK);
      chk("s5_no_ack", 32'(R1_ACK), 32'd0);
    end
    #1 RESET_N = 1'b1;

    // R0 alone, three back-to-back requests.
    settle();
    do_reset();
    R0_REQ = 1'b1; R0_WE = 1'b1; R0_WD = 32'hA5A5_0001;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      chk("s6_r0_ack", 32'(R0_ACK), 32'(k == 3 || k == 7 || k == 11));
      if (k <= 11) chk("s6_last_gnt", 32'(LAST_GNT), 32'd0);
      if (k == 11) R0_REQ = 1'b0;
    end
    chk("s6_idle", 32'(BUSY), 32'd0);

    // Randomized traffic with occasional mid-flight resets.
    settle();
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      if (R0_ACK && $urandom_range(1, 0) == 1)    R0_REQ = 1'b0;
      else if (!R0_REQ && $urandom_range(3, 0) == 0) R0_REQ = 1'b1;
      else if ($urandom_range(31, 0) == 0)         R0_REQ = 1'b0;
      if (R1_ACK && $urandom_range(1, 0) == 1)    R1_REQ = 1'b0;
      else if (!R1_REQ && $urandom_range(3, 0) == 0) R1_REQ = 1'b1;
      else if ($urandom_range(31, 0) == 0)         R1_REQ = 1'b0;
      R0_WE = 1'($urandom); R0_RE = 1'($urandom);
      R1_WE = 1'($urandom); R1_RE = 1'($urandom);
      R0_ADDR = AW'($urandom); R1_ADDR = AW'($urandom);
      R0_WD = $urandom; R1_WD = $urandom;
      IO_RD = $urandom;
      if ($urandom_range(299, 0) == 0) begin
        #1 RESET_N = 1'b0;
        @(negedge CLK);
        #1 RESET_N = 1'b1;
      end
    end

    settle();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/io_arbiter.md
IO_ARBITER -- requirements
Module: io_arbiter

Interface
REQ-001 The module SHALL have parameter RAM_DEPTH, default 14, setting the IO address width in bits.
REQ-002 The module SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 The module SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-004 The module SHALL have port R0_REQ  input  1  requester 0 (CPU) request; held high until R0_ACK is seen.
REQ-005 The module SHALL have ports R0_WE / R0_RE  input  1 each  requester 0 write / read strobe.
REQ-006 The module SHALL have port R0_ADDR  input  RAM_DEPTH  requester 0 IO address.
REQ-007 The module SHALL have port R0_WD  input  32  requester 0 write data.
REQ-008 The module SHALL have port R0_ACK  output  1  one-cycle completion pulse to requester 0.
REQ-009 The module SHALL have port R0_RD  output  32  requester 0 read data, valid while R0_ACK is high and held afterwards.
REQ-010 The module SHALL have ports R1_REQ, R1_WE, R1_RE, R1_ADDR, R1_WD, R1_ACK, R1_RD, identical in width and meaning to REQ-004..009, for requester 1 (debug/DMA).
REQ-011 The module SHALL have ports IO_REQ, IO_WE, IO_RE  output  1 each  downstream IO space request and strobes.
REQ-012 The module SHALL have port IO_ADDR  output  RAM_DEPTH  downstream address.
REQ-013 The module SHALL have port IO_WD  output  32  downstream write data.
REQ-014 The module SHALL have port IO_RD  input  32  downstream read data, valid one cycle after an IO_REQ cycle.
REQ-015 The module SHALL have port BUSY  output  1  high whenever state is not IDLE.
REQ-016 The module SHALL have port LAST_GNT  output  1  index of the most recently granted requester.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, CAPT and ACK, traversed IDLE->ISSUE->CAPT->ACK->IDLE with no skips and no stalls.
REQ-018 In IDLE, if any Rx_REQ is high, the FSM SHALL select a winner, register its WE/RE/ADDR/WD, store the winner index and move to ISSUE; otherwise it SHALL stay in IDLE.
REQ-019 Arbitration SHALL be: a single requester wins; if both request, the requester not equal to LAST_GNT wins (round-robin).
REQ-020 LAST_GNT SHALL update to the winner index on the IDLE->ISSUE edge.
REQ-021 In ISSUE, IO_REQ SHALL be 1 for exactly one cycle, with IO_WE, IO_RE, IO_ADDR and IO_WD driven from the registered request.
REQ-022 If both WE and RE are set in a request, the arbiter SHALL issue it as a write (IO_WE=1, IO_RE=0).
REQ-023 A request with WE=RE=0 SHALL still complete the full sequence and return an ACK.
REQ-024 Outside ISSUE, IO_REQ, IO_WE and IO_RE SHALL be 0, and IO_ADDR and IO_WD SHALL hold the last registered values.
REQ-025 In CAPT, the arbiter SHALL capture IO_RD into the winner's Rx_RD register; the other port's Rx_RD SHALL be unchanged.
REQ-026 In ACK, the arbiter SHALL assert only the winner's Rx_ACK for exactly one cycle.
REQ-027 Latency SHALL be exactly 3 cycles from the IDLE cycle that samples Rx_REQ to the Rx_ACK cycle, for a 4-cycle occupancy per transaction.
REQ-028 After ACK, the FSM SHALL return to IDLE and sample requests there; a requester that keeps REQ high after its ACK SHALL be treated as a new request.
REQ-029 Dropping Rx_REQ or changing Rx_* inputs after the grant SHALL NOT affect the transaction in flight; the transaction SHALL complete and ACK SHALL still pulse.
REQ-030 A request arriving from the other requester while BUSY SHALL wait and SHALL be served at the next IDLE.

Reset
REQ-031 When RESET_N is low, the arbiter SHALL asynchronously force: state=IDLE, all outputs 0, R0_RD=R1_RD=0, and LAST_GNT=1 (so R0 wins the first tie).
REQ-032 A reset asserted mid-transaction SHALL abort the transaction with no ACK issued.
REQ-033 After reset release, the first possible grant SHALL occur on the first rising edge with RESET_N high.

Verification
REQ-034 Scenario: R0 read at addr 0x010 with IO_RD=0xDEADBEEF in CAPT -> IO_REQ=1, IO_RE=1 in cycle 1, R0_ACK in cycle 3, R0_RD=0xDEADBEEF, R1_RD stays 0.
REQ-035 Scenario: both requesters hold REQ continuously after reset -> grant order R0, R1, R0, R1, with ACKs spaced 4 cycles apart.
REQ-036 Scenario: R1 write with WE=RE=1, addr 0x030, WD=0x12345678 -> one ISSUE cycle with IO_WE=1, IO_RE=0, IO_ADDR=0x030, IO_WD=0x12345678.
REQ-037 Scenario: R0 drops REQ during CAPT -> R0_ACK still pulses in the ACK cycle, and the FSM returns to IDLE and then remains idle.
REQ-038 Scenario: RESET_N pulsed low during ISSUE -> IO_REQ=0 immediately, no Rx_ACK, BUSY=0, LAST_GNT=1.
REQ-039 Scenario: R0 only, three back-to-back requests -> three ACKs at cycles 3, 7 and 11, with LAST_GNT=0 throughout.
